// File: rtl/awithb_sweeper.sv
// Stimulus sweeper and response checker for the A/B gate circuit (z = x | ~y).
// Optional build macro AWITHB_SWEEPER_STOP_ON_FAIL_EN ends a run at its first mismatch.
`timescale 1ns/1ps
module awithb_sweeper #(
  parameter logic [7:0] SETTLE = 8'd1,
  parameter logic [7:0] ROUNDS = 8'd1
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       start,
  input  logic       dut_z,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  v_r, v_s;
  logic [7:0]  settle_r, settle_s;
  logic [7:0]  round_r, round_s;
  logic [3:0]  mask_r, mask_s;
  logic        pass_r, pass_s;
  logic        x_r, x_s, y_r, y_s, busy_r, busy_s, done_r, done_s;
  logic        hit_s, last_s;
  logic [3:0]  vbit_s;

  function automatic logic ref_z(input logic [1:0] vec);
    return vec[1] | ~vec[0];
  endfunction

  // Next-state, counter and output decode; outputs derive from the next state so they register glitch-free.
  always_comb begin
    state_s  = state_r;
    v_s      = v_r;
    settle_s = settle_r;
    round_s  = round_r;
    mask_s   = mask_r;
    pass_s   = pass_r;
    hit_s    = (dut_z != ref_z(v_r));
    last_s   = (v_r == 2'd3) && (round_r == 8'd1);
    vbit_s   = 4'b0001 << v_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s  = DRIVE;
          v_s      = 2'd0;
          mask_s   = 4'd0;
          pass_s   = 1'b0;
          settle_s = SETTLE;
          round_s  = ROUNDS;
        end else begin
          state_s  = IDLE;
        end
      end
      DRIVE: begin
        if (settle_r == 8'd1) begin
          settle_s = SETTLE;
          v_s      = v_r + 2'd1;
`ifdef AWITHB_SWEEPER_STOP_ON_FAIL_EN
          if (hit_s) begin
            mask_s  = vbit_s;
            pass_s  = 1'b0;
            state_s = DONE;
          end else if (last_s) begin
            state_s = DONE;
            round_s = 8'd0;
            pass_s  = (mask_r == 4'd0);
          end else if (v_r == 2'd3) begin
            round_s = round_r - 8'd1;
          end else begin
            round_s = round_r;
          end
`else
          mask_s = hit_s ? (mask_r | vbit_s) : mask_r;
          if (last_s) begin
            state_s = DONE;
            round_s = 8'd0;
            pass_s  = (mask_s == 4'd0);
          end else if (v_r == 2'd3) begin
            round_s = round_r - 8'd1;
          end else begin
            round_s = round_r;
          end
`endif
        end else begin
          settle_s = settle_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == DRIVE);
    done_s = (state_s == DONE);
    x_s    = busy_s & v_s[1];
    y_s    = busy_s & v_s[0];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r  <= IDLE;
      v_r      <= 2'd0;
      settle_r <= 8'd0;
      round_r  <= 8'd0;
      mask_r   <= 4'd0;
      pass_r   <= 1'b0;
      x_r      <= 1'b0;
      y_r      <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      v_r      <= v_s;
      settle_r <= settle_s;
      round_r  <= round_s;
      mask_r   <= mask_s;
      pass_r   <= pass_s;
      x_r      <= x_s;
      y_r      <= y_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign x         = x_r;
  assign y         = y_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_mask = mask_r;

endmodule

// File: tb/tb_awithb_sweeper.sv
// Directed bench for awithb_sweeper: two instances (defaults, and SETTLE=2/ROUNDS=3) against a modelled DUT.
`timescale 1ns/1ps
module tb_awithb_sweeper;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [1:0] mode1 = 2'd0, mode2 = 2'd1;
  logic       z1, z2;
  logic       x1, y1, busy1, done1, pass1;
  logic       x2, y2, busy2, done2, pass2;
  logic [3:0] mask1, mask2;
  logic [8:0] st1, st2;
  int         total = 0;
  int         bad = 0;
  logic [1:0] vv;

  always #5 clk = ~clk;

  // mode 0: correct circuit, 1: stuck at 0, 2: inverted only for vector 01
  function automatic logic model_z(input logic [1:0] m, input logic xx, input logic yy);
    case (m)
      2'd0:    return xx | ~yy;
      2'd1:    return 1'b0;
      2'd2:    return (xx | ~yy) ^ (~xx & yy);
      default: return 1'b0;
    endcase
  endfunction

  assign z1  = model_z(mode1, x1, y1);
  assign z2  = model_z(mode2, x2, y2);
  assign st1 = {busy1, done1, pass1, x1, y1, mask1};
  assign st2 = {busy2, done2, pass2, x2, y2, mask2};

  awithb_sweeper u_dut1 (
    .clk(clk), .areset_n(areset_n), .start(start1), .dut_z(z1),
    .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1)
  );

  awithb_sweeper #(.SETTLE(8'd2), .ROUNDS(8'd3)) u_dut2 (
    .clk(clk), .areset_n(areset_n), .start(start2), .dut_z(z2),
    .x(x2), .y(y2), .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2)
  );

  function automatic logic [8:0] e(input logic b, input logic d, input logic p,
                                   input logic [1:0] xy, input logic [3:0] m);
    return {b, d, p, xy, m};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick; tick;
    chk("reset1", st1, 9'd0);
    chk("reset2", st2, 9'd0);
    areset_n = 1'b1;
    tick;

    // correct DUT, defaults
    mode1 = 2'd0;
    start1 = 1'b1; tick; start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vv = 2'(k);
      chk($sformatf("seq%0d", k), st1, e(1'b1, 1'b0, 1'b0, vv, 4'd0));
      tick;
    end
    chk("done_ok", st1, e(1'b0, 1'b1, 1'b1, 2'd0, 4'd0));
    tick;
    chk("idle_hold", st1, e(1'b0, 1'b0, 1'b1, 2'd0, 4'd0));

    // DUT wrong only on vector 01
    mode1 = 2'd2;
    start1 = 1'b1; tick; start1 = 1'b0;
    chk("flip_v0", st1, e(1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    tick;
    chk("flip_v1", st1, e(1'b1, 1'b0, 1'b0, 2'd1, 4'd0));
    tick;
`ifdef AWITHB_SWEEPER_STOP_ON_FAIL_EN
    chk("flip_stop_done", st1, e(1'b0, 1'b1, 1'b0, 2'd0, 4'b0010));
    tick;
    chk("flip_stop_idle", st1, e(1'b0, 1'b0, 1'b0, 2'd0, 4'b0010));
`else
    chk("flip_v2", st1, e(1'b1, 1'b0, 1'b0, 2'd2, 4'b0010));
    tick;
    chk("flip_v3", st1, e(1'b1, 1'b0, 1'b0, 2'd3, 4'b0010));
    tick;
    chk("flip_done", st1, e(1'b0, 1'b1, 1'b0, 2'd0, 4'b0010));
    tick;
`endif

    // stuck-at-0 DUT, SETTLE=2 ROUNDS=3
    start2 = 1'b1; tick; start2 = 1'b0;
`ifdef AWITHB_SWEEPER_STOP_ON_FAIL_EN
    chk("stuck_c1", st2, e(1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    tick;
    chk("stuck_c2", st2, e(1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    tick;
    chk("stuck_stop_done", st2, e(1'b0, 1'b1, 1'b0, 2'd0, 4'b0001));
    tick;
`else
    for (int k = 1; k <= 24; k++) begin
      vv = 2'((k - 1) / 2);
      chk($sformatf("stuck_c%0d", k), {5'd0, busy2, done2, x2, y2}, {5'd0, 1'b1, 1'b0, vv});
      tick;
    end
    chk("stuck_done", st2, e(1'b0, 1'b1, 1'b0, 2'd0, 4'b1101));
    tick;
    chk("stuck_idle", st2, e(1'b0, 1'b0, 1'b0, 2'd0, 4'b1101));
`endif

    // asynchronous reset during vector 2
    mode1 = 2'd0;
    start1 = 1'b1; tick; start1 = 1'b0;
    tick; tick;
    chk("pre_rst_v2", st1, e(1'b1, 1'b0, 1'b0, 2'd2, 4'd0));
    #2 areset_n = 1'b0;
    #1 chk("async_rst", st1, 9'd0);
    tick;
    chk("rst_held", st1, 9'd0);
    areset_n = 1'b1;
    tick;
    chk("post_rst_idle", st1, 9'd0);
    start1 = 1'b1; tick; start1 = 1'b0;
    chk("clean_v0", st1, e(1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    tick; tick; tick; tick;
    chk("clean_done", st1, e(1'b0, 1'b1, 1'b1, 2'd0, 4'd0));
    tick;

    // back-to-back starts
    start1 = 1'b1; tick; start1 = 1'b0;
    chk("b2b_v0", st1, e(1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    start1 = 1'b1; tick; start1 = 1'b0;
    chk("b2b_ign_v1", st1, e(1'b1, 1'b0, 1'b0, 2'd1, 4'd0));
    tick;
    chk("b2b_v2", st1, e(1'b1, 1'b0, 1'b0, 2'd2, 4'd0));
    tick; tick;
    chk("b2b_done", st1, e(1'b0, 1'b1, 1'b1, 2'd0, 4'd0));
    start1 = 1'b1; tick; start1 = 1'b0;
    chk("b2b_restart", st1, e(1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    tick; tick; tick; tick;
    chk("b2b_done2", st1, e(1'b0, 1'b1, 1'b1, 2'd0, 4'd0));
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
